// File: rtl/otter_mmio_hub.sv
// MMIO hub for the OTTER IOBUS: decoded input/output port slots plus an
// edge-triggered interrupt controller (pending, enable and cause registers).
module otter_mmio_hub #(
    parameter int          N_IN    = 2,
    parameter int          N_OUT   = 4,
    parameter int          N_IRQ   = 4,
    parameter logic [31:0] BASE_AD = 32'h1100_0000,
    parameter int          SLOT_SH = 18,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    input  logic [N_IN*32-1:0]    PORT_IN,
    output logic [N_OUT*32-1:0]   PORT_OUT,
    input  logic [N_IRQ-1:0]      IRQ_SRC,
    output logic                  INT
);

    localparam logic [4:0] SLOT_PEND  = 5'd16;
    localparam logic [4:0] SLOT_EN    = 5'd17;
    localparam logic [4:0] SLOT_CAUSE = 5'd18;

    logic                       hit;
    logic                       wr_hit;
    logic [4:0]                 slot;

    logic [N_IN*32-1:0]         in_p0, in_p1;
    logic [N_IRQ-1:0]           irq_p0, irq_p1, irq_prev;
    logic [1:0]                 arm_cnt;
    logic [N_IRQ-1:0]           pend, en;
    logic [N_IRQ-1:0]           rise, w1c, pend_nxt, act;
    logic [N_OUT-1:0][31:0]     out_r;
    logic                       int_r;
    logic [31:0]                cause;
    logic [31:0]                rdata;

    assign slot   = IOBUS_ADDR[SLOT_SH +: 5];
    assign hit    = (IOBUS_ADDR[SLOT_SH-1:0] == '0) &&
                    (IOBUS_ADDR[31:SLOT_SH+5] == BASE_AD[31:SLOT_SH+5]);
    assign wr_hit = IOBUS_WR && hit;

    // Interrupt update: a fresh rising edge always wins over a same-cycle clear
    always_comb begin
        rise     = (arm_cnt == 2'd3) ? (irq_p1 & ~irq_prev) : '0;
        w1c      = (wr_hit && slot == SLOT_PEND) ? IOBUS_OUT[N_IRQ-1:0] : '0;
        pend_nxt = rise | (pend & ~w1c);
        act      = pend & en;
    end

    always_comb begin
        cause = 32'hFFFF_FFFF;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (act[i]) cause = 32'(i);
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            for (int i = 0; i < N_IN; i++) begin
                if (slot == 5'(i)) rdata = in_p1[32*i +: 32];
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (slot == 5'(8 + j)) rdata = out_r[j];
            end
            if (slot == SLOT_PEND)  rdata = 32'(pend);
            if (slot == SLOT_EN)    rdata = 32'(en);
            if (slot == SLOT_CAUSE) rdata = cause;
        end
    end

    // Stage p0/p1: two-flop synchronisers; irq_prev holds the last synced IRQ level
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_p0    <= '0;
            in_p1    <= '0;
            irq_p0   <= '0;
            irq_p1   <= '0;
            irq_prev <= '0;
            arm_cnt  <= 2'd0;
            pend     <= '0;
            en       <= '0;
            int_r    <= 1'b0;
            for (int j = 0; j < N_OUT; j++) out_r[j] <= OUT_RST;
        end else begin
            in_p0    <= PORT_IN;
            in_p1    <= in_p0;
            irq_p0   <= IRQ_SRC;
            irq_p1   <= irq_p0;
            irq_prev <= irq_p1;
            // Edges are ignored until the synchroniser has flushed its reset state
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
            pend     <= pend_nxt;
            int_r    <= |act;
            if (wr_hit && slot == SLOT_EN) en <= IOBUS_OUT[N_IRQ-1:0];
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_hit && slot == 5'(8 + j)) out_r[j] <= IOBUS_OUT;
            end
        end
    end

    assign IOBUS_IN = rdata;
    assign PORT_OUT = out_r;
    assign INT      = int_r;

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Directed bench for otter_mmio_hub: expectations are queued when stimulus is
// driven and popped against DUT outputs sampled on the falling clock edge.
module tb_otter_mmio_hub;

    localparam logic [31:0] A_IN0   = 32'h1100_0000;
    localparam logic [31:0] A_SLOT2 = 32'h1108_0000;
    localparam logic [31:0] A_OUT0  = 32'h1120_0000;
    localparam logic [31:0] A_OUT1  = 32'h1124_0000;
    localparam logic [31:0] A_PEND  = 32'h1140_0000;
    localparam logic [31:0] A_EN    = 32'h1144_0000;
    localparam logic [31:0] A_CAUSE = 32'h1148_0000;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  IOBUS_ADDR;
    logic [31:0]  IOBUS_OUT;
    logic         IOBUS_WR;
    logic [31:0]  IOBUS_IN;
    logic [63:0]  PORT_IN;
    logic [127:0] PORT_OUT;
    logic [3:0]   IRQ_SRC;
    logic         INT;

    int n_cmp = 0;
    int n_bad = 0;
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    otter_mmio_hub dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .PORT_IN(PORT_IN),
        .PORT_OUT(PORT_OUT), .IRQ_SRC(IRQ_SRC), .INT(INT)
    );

    always #5 CLK = ~CLK;

    task automatic push(input string tag, input logic [31:0] e);
        sb_tag.push_back(tag);
        sb_exp.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (sb_exp.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            t = sb_tag.pop_front();
            e = sb_exp.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = a;
        #1 d = IOBUS_IN;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        push(tag, e);
        rd(a, d);
        compare(d);
    endtask

    task automatic chk_int(input string tag, input logic e);
        push(tag, {31'd0, e});
        #1 compare({31'd0, INT});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    initial begin
        RST = 1'b1; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
        PORT_IN = '0; IRQ_SRC = 4'b0001;   // bit 0 held high through reset release
        cyc(3);
        RST = 1'b0;

        push("rst_port_out_lo", 32'h0); #1 compare(PORT_OUT[31:0]);
        push("rst_port_out_hi", 32'h0); compare(PORT_OUT[127:96]);
        chk_int("rst_int", 1'b0);
        chk_rd("rst_cause", A_CAUSE, 32'hFFFF_FFFF);

        // Unmapped slot and off-grid address must not change anything
        wr(A_SLOT2, 32'hA5A5);
        wr(A_OUT0 + 32'h4, 32'h5A5A);
        push("unmapped_no_write", 32'h0); #1 compare(PORT_OUT[31:0]);
        chk_rd("unmapped_read", A_SLOT2, 32'h0);

        wr(A_OUT0, 32'hA5A5);
        push("out0_port", 32'hA5A5); #1 compare(PORT_OUT[31:0]);
        chk_rd("out0_readback", A_OUT0, 32'hA5A5);
        wr(A_OUT1, 32'hDEAD_BEEF);
        push("out1_port", 32'hDEAD_BEEF); #1 compare(PORT_OUT[63:32]);
        push("out0_kept", 32'hA5A5); compare(PORT_OUT[31:0]);

        // Input synchroniser latency: two edges
        PORT_IN[31:0] = 32'h1234;
        chk_rd("in0_t0", A_IN0, 32'h0);
        cyc(1); chk_rd("in0_t1", A_IN0, 32'h0);
        cyc(1); chk_rd("in0_t2", A_IN0, 32'h1234);

        chk_rd("pend_arm_suppress", A_PEND, 32'h0);

        wr(A_EN, 32'hFFFF_FFFF);
        chk_rd("en_mask_width", A_EN, 32'hF);
        wr(A_EN, 32'h5);
        chk_rd("en_readback", A_EN, 32'h5);

        // Pulse source 2 for one cycle: pending after 3 edges, INT one edge later
        IRQ_SRC = 4'b0101; cyc(1);
        IRQ_SRC = 4'b0001; cyc(1);
        chk_rd("pend2_not_yet", A_PEND, 32'h0);
        cyc(1);
        chk_rd("pend2_set", A_PEND, 32'h4);
        chk_int("int_lag", 1'b0);
        cyc(1);
        chk_int("int_set", 1'b1);
        chk_rd("cause2", A_CAUSE, 32'h2);

        wr(A_PEND, 32'h4);
        chk_rd("pend2_cleared", A_PEND, 32'h0);
        cyc(1);
        chk_int("int_cleared", 1'b0);

        // Disabled source latches but keeps INT low
        IRQ_SRC = 4'b0011; cyc(1);
        IRQ_SRC = 4'b0001; cyc(2);
        chk_rd("pend1_disabled", A_PEND, 32'h2);
        cyc(1);
        chk_int("int_disabled", 1'b0);
        chk_rd("cause_disabled", A_CAUSE, 32'hFFFF_FFFF);
        wr(A_PEND, 32'h2);
        chk_rd("pend1_cleared", A_PEND, 32'h0);

        // Clear lands on the same edge as a new rise on bit 1: set wins
        IRQ_SRC = 4'b0011; cyc(1);
        IRQ_SRC = 4'b0001; cyc(1);
        wr(A_PEND, 32'h2);
        chk_rd("set_beats_clear", A_PEND, 32'h2);

        wr(A_EN, 32'h7);
        chk_int("int_after_enable_lag", 1'b0);
        cyc(1);
        chk_int("int_after_enable", 1'b1);
        chk_rd("cause1", A_CAUSE, 32'h1);

        // Reset wins over a simultaneous EN write
        IOBUS_ADDR = A_EN; IOBUS_OUT = 32'h0; IOBUS_WR = 1'b1; RST = 1'b1;
        cyc(1);
        IOBUS_WR = 1'b0; RST = 1'b0;
        chk_rd("rst_over_write_en", A_EN, 32'h0);
        chk_rd("rst_pend", A_PEND, 32'h0);
        chk_int("rst_int2", 1'b0);
        push("rst_port_out2", 32'h0); #1 compare(PORT_OUT[31:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
